// File: rtl/rib_wdt.sv
// rib_wdt: watchdog timer on a rib slave port.
// Software arms it with a reload value and must write KICK_KEY to KICK before
// the count runs out. The first expiry raises WARN (interrupt); a second expiry
// without a kick, or a wrong kick value, enters BITE and issues a fixed-length
// reset request pulse to the SoC reset logic.
//
// state | meaning
// IDLE  | disabled, COUNT follows LOAD
// RUN   | counting, no warning outstanding
// WARN  | first expiry seen, counting towards BITE
// BITE  | reset request pulse in progress, returns to IDLE when done
module rib_wdt #(
  parameter logic [15:0] PRESC_DIV = 16'd1,
  parameter logic [7:0]  RST_PULSE = 8'd16,
  parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o,
  output logic        rst_req_o
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_LOAD   = 8'h04;
  localparam logic [7:0] A_COUNT  = 8'h08;
  localparam logic [7:0] A_KICK   = 8'h0C;
  localparam logic [7:0] A_STATUS = 8'h10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WARN, S_BITE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;      // {LOCK, INT_EN, RST_EN, EN}
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  status_q, status_d;  // {BITE, WARN}
  logic [15:0] presc_q, presc_d;
  logic [7:0]  pulse_q, pulse_d;

  logic [7:0]  addr_lo;
  logic        wr_ctrl, wr_load, wr_kick, wr_status;
  logic        tick, kick_ok;
  logic        unused_addr;

  assign addr_lo     = addr_i[7:0];
  assign unused_addr = ^addr_i[31:8];

  // CTRL and LOAD are frozen once LOCK is set
  assign wr_ctrl   = we_i && (addr_lo == A_CTRL) && !ctrl_q[3];
  assign wr_load   = we_i && (addr_lo == A_LOAD) && !ctrl_q[3];
  assign wr_kick   = we_i && (addr_lo == A_KICK);
  assign wr_status = we_i && (addr_lo == A_STATUS);
  assign kick_ok   = (data_i == KICK_KEY);
  assign tick      = (presc_q == (PRESC_DIV - 16'd1));

  assign int_sig_o = status_q[0] & ctrl_q[2];
  // pulse_q is only nonzero while in BITE
  assign rst_req_o = ctrl_q[1] & (pulse_q != 8'd0);

  // Register read decode, combinational from the address
  always_comb begin
    data_o = 32'd0;
    case (addr_lo)
      A_CTRL:   data_o = {28'd0, ctrl_q};
      A_LOAD:   data_o = load_q;
      A_COUNT:  data_o = count_q;
      A_STATUS: data_o = {30'd0, status_q};
      default:  data_o = 32'd0;
    endcase
  end

  // Next-state: register writes, prescaler, counter and watchdog FSM
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    count_d  = count_q;
    status_d = status_q;
    presc_d  = presc_q;
    pulse_d  = pulse_q;

    if (wr_ctrl) begin
      ctrl_d = {ctrl_q[3] | data_i[3], data_i[2:0]};
    end
    if (wr_load) begin
      load_d = data_i;
    end
    // W1C first so that a hardware set later in this block wins
    if (wr_status && data_i[0]) begin
      status_d[0] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        count_d = load_q;
        presc_d = 16'd0;
        if (wr_ctrl && data_i[0] && !ctrl_q[0]) begin
          state_d = S_RUN;
        end
      end

      S_RUN, S_WARN: begin
        if (wr_ctrl && !data_i[0]) begin
          state_d = S_IDLE;
          presc_d = 16'd0;
        end else if (wr_kick && kick_ok) begin
          // a kick beats an expiry landing on the same edge
          count_d     = load_q;
          presc_d     = 16'd0;
          status_d[0] = 1'b0;
          state_d     = S_RUN;
        end else if (wr_kick) begin
          status_d[1] = 1'b1;
          ctrl_d[0]   = 1'b0;
          pulse_d     = RST_PULSE;
          presc_d     = 16'd0;
          state_d     = S_BITE;
        end else begin
          presc_d = tick ? 16'd0 : presc_q + 16'd1;
          if (tick) begin
            if (count_q != 32'd0) begin
              count_d = count_q - 32'd1;
            end else if (state_q == S_RUN) begin
              status_d[0] = 1'b1;
              count_d     = load_q;
              presc_d     = 16'd0;
              state_d     = S_WARN;
            end else begin
              status_d[1] = 1'b1;
              ctrl_d[0]   = 1'b0;
              pulse_d     = RST_PULSE;
              presc_d     = 16'd0;
              state_d     = S_BITE;
            end
          end
        end
      end

      S_BITE: begin
        presc_d = 16'd0;
        if (pulse_q <= 8'd1) begin
          pulse_d = 8'd0;
          state_d = S_IDLE;
        end else begin
          pulse_d = pulse_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      load_q   <= 32'hFFFF_FFFF;
      count_q  <= 32'hFFFF_FFFF;
      status_q <= 2'd0;
      presc_q  <= 16'd0;
      pulse_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      count_q  <= count_d;
      status_q <= status_d;
      presc_q  <= presc_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: tb/tb_rib_wdt.sv
// tb_rib_wdt: scenario tasks for the rib watchdog. Each task pushes expected
// values as it drives stimulus, records DUT observations, then pops and compares.
module tb_rib_wdt;
  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_COUNT  = 32'h08;
  localparam logic [31:0] A_KICK   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst, we, sel;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata4;
  logic        irq, rreq, irq4, rreq4;

  int n_assert = 0;
  int n_fail   = 0;

  string       exp_name[$];
  logic [31:0] exp_val[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  rib_wdt dut (
    .clk(clk), .rst(rst), .we_i(we & ~sel), .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .int_sig_o(irq), .rst_req_o(rreq)
  );

  rib_wdt #(.PRESC_DIV(16'd4)) dut4 (
    .clk(clk), .rst(rst), .we_i(we & sel), .addr_i(addr), .data_i(wdata),
    .data_o(rdata4), .int_sig_o(irq4), .rst_req_o(rreq4)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic grab(input logic [31:0] a);
    addr = a;
    #1;
    obs_q.push_back(sel ? rdata4 : rdata);
  endtask

  task automatic grab_bit(input logic b);
    obs_q.push_back({31'd0, b});
  endtask

  task automatic expect_v(input string n, input logic [31:0] v);
    exp_name.push_back(n);
    exp_val.push_back(v);
  endtask

  task automatic do_rst();
    rst = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    string nm; logic [31:0] ev, ov;
    sel = 1'b0;
    do_rst();
    expect_v("ctrl", 32'h0);          grab(A_CTRL);
    expect_v("load", 32'hFFFF_FFFF);  grab(A_LOAD);
    expect_v("count", 32'hFFFF_FFFF); grab(A_COUNT);
    expect_v("kick", 32'h0);          grab(A_KICK);
    expect_v("status", 32'h0);        grab(A_STATUS);
    expect_v("unmapped", 32'h0);      grab(32'h14);
    expect_v("alias_load", 32'hFFFF_FFFF); grab(32'h104);
    expect_v("irq", 32'h0);  grab_bit(irq);
    expect_v("rreq", 32'h0); grab_bit(rreq);
    wr(32'h20, 32'h1234_5678);
    wr(A_KICK, 32'h1234_5678);
    step(3);
    expect_v("unmapped_wr", 32'h0);      grab(32'h20);
    expect_v("load_after", 32'hFFFF_FFFF); grab(A_LOAD);
    expect_v("idle_kick_status", 32'h0); grab(A_STATUS);
    expect_v("idle_kick_rreq", 32'h0);   grab_bit(rreq);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL reset.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_warn_bite();
    string nm; logic [31:0] ev, ov;
    logic any_rreq;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);                 // enable captured at edge 0
    expect_v("count_start", 32'd3); grab(A_COUNT);
    step(3);                           // edge 3
    expect_v("status_e3", 32'h0); grab(A_STATUS);
    wr(A_STATUS, 32'h1);               // W1C on the expiry edge 4
    expect_v("warn_set_wins", 32'h1); grab(A_STATUS);
    expect_v("irq_e4", 32'h1); grab_bit(irq);
    expect_v("count_reload", 32'd3); grab(A_COUNT);
    wr(A_STATUS, 32'h1);               // edge 5 clears WARN
    expect_v("warn_w1c", 32'h0); grab(A_STATUS);
    expect_v("irq_cleared", 32'h0); grab_bit(irq);
    step(2);                           // edge 7
    expect_v("status_e7", 32'h0); grab(A_STATUS);
    step(1);                           // edge 8
    expect_v("bite_status", 32'h2); grab(A_STATUS);
    expect_v("bite_ctrl", 32'h4); grab(A_CTRL);
    any_rreq = rreq;
    for (int i = 0; i < 20; i++) begin
      step(1);
      any_rreq = any_rreq | rreq;
    end
    expect_v("rreq_no_rst_en", 32'h0); grab_bit(any_rreq);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL warn_bite.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bite_pulse();
    string nm; logic [31:0] ev, ov;
    int first, last, cnt;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h7);                 // edge 0
    expect_v("pulse_first", 32'd8);
    expect_v("pulse_last", 32'd23);
    expect_v("pulse_len", 32'd16);
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rreq) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      step(1);
    end
    obs_q.push_back(first); obs_q.push_back(last); obs_q.push_back(cnt);
    expect_v("status", 32'h3); grab(A_STATUS);
    expect_v("ctrl", 32'h6); grab(A_CTRL);
    expect_v("irq", 32'h1); grab_bit(irq);
    wr(A_LOAD, 32'd7);
    step(1);
    expect_v("idle_tracks_load", 32'd7); grab(A_COUNT);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL bite_pulse.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_kick();
    string nm; logic [31:0] ev, ov;
    logic bad;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h7);                 // edge 0
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wr(A_KICK, KEY);
      bad = bad | irq | rreq;
      step(1); bad = bad | irq | rreq;
      step(1); bad = bad | irq | rreq;
    end
    expect_v("no_warn_or_rreq", 32'h0); grab_bit(bad);
    expect_v("status_kicked", 32'h0); grab(A_STATUS);
    expect_v("count_mid", 32'd1); grab(A_COUNT);
    step(2);
    expect_v("warn_after_stop", 32'h1); grab(A_STATUS);
    expect_v("irq_warn", 32'h1); grab_bit(irq);
    wr(A_KICK, KEY);
    expect_v("kick_clears_warn", 32'h0); grab(A_STATUS);
    expect_v("kick_clears_irq", 32'h0); grab_bit(irq);
    expect_v("kick_reload", 32'd3); grab(A_COUNT);
    step(3);
    wr(A_KICK, KEY);                   // lands on the expiry edge
    expect_v("kick_beats_expiry", 32'h0); grab(A_STATUS);
    expect_v("kick_beats_count", 32'd3); grab(A_COUNT);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL kick.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_disable();
    string nm; logic [31:0] ev, ov;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    step(4);
    expect_v("warn", 32'h1); grab(A_STATUS);
    wr(A_CTRL, 32'h4);
    step(12);
    expect_v("status_kept", 32'h1); grab(A_STATUS);
    expect_v("irq_kept", 32'h1); grab_bit(irq);
    expect_v("ctrl", 32'h4); grab(A_CTRL);
    expect_v("count_idle", 32'd3); grab(A_COUNT);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL disable.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bad_kick();
    string nm; logic [31:0] ev, ov;
    int first, cnt;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'h7);
    step(2);
    wr(A_KICK, 32'h1234_5678);
    expect_v("bite_status", 32'h2); grab(A_STATUS);
    expect_v("bite_ctrl", 32'h6); grab(A_CTRL);
    expect_v("pulse_first", 32'd0);
    expect_v("pulse_len", 32'd16);
    first = -1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rreq) begin
        if (first < 0) first = i;
        cnt++;
      end
      if (i == 3) begin
        we = 1'b1; addr = A_KICK; wdata = KEY;
      end else begin
        we = 1'b0;
      end
      step(1);
    end
    obs_q.push_back(first); obs_q.push_back(cnt);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL bad_kick.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_lock();
    string nm; logic [31:0] ev, ov;
    sel = 1'b0;
    do_rst();
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'hF);                 // edge 0, COUNT=100
    wr(A_CTRL, 32'h0);                 // edge 1
    wr(A_LOAD, 32'h10);                // edge 2
    expect_v("ctrl_locked", 32'hF); grab(A_CTRL);
    expect_v("load_locked", 32'd100); grab(A_LOAD);
    expect_v("count_e2", 32'd98); grab(A_COUNT);
    step(2);
    expect_v("count_e4", 32'd96); grab(A_COUNT);
    wr(A_KICK, KEY);
    expect_v("kick_reload", 32'd100); grab(A_COUNT);
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL lock.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_presc();
    string nm; logic [31:0] ev, ov;
    sel = 1'b1;
    do_rst();
    wr(A_LOAD, 32'd0);
    wr(A_CTRL, 32'h7);                 // edge 0
    step(3);
    expect_v("status_e3", 32'h0); grab(A_STATUS);
    step(1);
    expect_v("warn_e4", 32'h1); grab(A_STATUS);
    expect_v("count_e4", 32'h0); grab(A_COUNT);
    step(3);
    expect_v("status_e7", 32'h1); grab(A_STATUS);
    step(1);
    expect_v("bite_e8", 32'h3); grab(A_STATUS);
    expect_v("rreq_e8", 32'h1); grab_bit(rreq4);
    step(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_v("rreq_after_rst", 32'h0); grab_bit(rreq4);
    expect_v("count_after_rst", 32'hFFFF_FFFF); grab(A_COUNT);
    expect_v("status_after_rst", 32'h0); grab(A_STATUS);
    expect_v("ctrl_after_rst", 32'h0); grab(A_CTRL);
    step(3);
    expect_v("rreq_stays_low", 32'h0); grab_bit(rreq4);
    sel = 1'b0;
    while (exp_val.size() > 0) begin
      nm = exp_name.pop_front(); ev = exp_val.pop_front(); n_assert++;
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL presc.%s: got %h expected %h", nm, ov, ev);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; sel = 1'b0; addr = 32'd0; wdata = 32'd0;
    step(2);
    test_reset();
    test_warn_bite();
    test_bite_pulse();
    test_kick();
    test_disable();
    test_bad_kick();
    test_lock();
    test_presc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
